// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin index arbiter.
package arb_pkg;

    localparam int unsigned N                = 8;
    localparam int unsigned IDX_W            = 3;
    localparam int unsigned DEFAULT_MAX_HOLD = 16;

    typedef enum logic {
        StIdle,
        StGrant
    } state_e;

endpackage

// File: rtl/rr_arb8_idx_if.sv
// Requester-side bus of the round-robin arbiter: request/release in, registered grant out.
interface rr_arb8_idx_if;
    import arb_pkg::*;

    logic [N-1:0]     req;
    // 'release' is a reserved word, so the owner's end-of-grant pulse is named rel
    logic             rel;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             timeout;

    modport master (
        output req,
        output rel,
        input  grant_valid,
        input  grant_idx,
        input  timeout
    );

    modport slave (
        input  req,
        input  rel,
        output grant_valid,
        output grant_idx,
        output timeout
    );

endinterface

// File: rtl/rr_pick8.sv
// Combinational rotating priority pick: first set request bit at or after ptr, with wrap.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // Natural 3-bit overflow gives the 7->0 wrap
            cand = ptr_i + i[IDX_W-1:0];
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb8_idx.sv
// Round-robin arbiter for 8 requesters; registers the winner as a 3-bit index with hold limit.
module rr_arb8_idx
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    rr_arb8_idx_if.slave  bus
);

    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_exit;
    logic             hold_exit;

    rr_pick8 u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    assign owner_exit = bus.rel || !bus.req[idx_q];
    assign hold_exit  = (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (owner_exit || hold_exit) begin
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + 1'b1;
                    state_d   = StIdle;
                    // Release or request drop takes precedence over the hold limit
                    timeout_d = hold_exit && !owner_exit;
                end else if (cnt_q != {CntW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.grant_valid = valid_q;
    assign bus.grant_idx   = idx_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arb8_idx.sv
// Self-checking bench for rr_arb8_idx: directed scenarios plus random traffic vs. a cycle model.
module tb_rr_arb8_idx;

    localparam int unsigned MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_arb8_idx_if bus ();

    rr_arb8_idx #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the resource, for how many cycles, and where the scan starts.
    bit         m_valid;
    bit         m_timeout;
    logic [2:0] m_idx;
    int         m_ptr;
    int         m_held;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int off = 0; off < 8; off++) begin
            if (r[(p + off) % 8]) return (p + off) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_timeout = 0; m_idx = 3'd0; m_ptr = 0; m_held = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rl);
        int  w;
        bit  drop;
        m_timeout = 0;
        if (!m_valid) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_valid = 1; m_idx = 3'(w); m_held = 1;
            end
        end else begin
            drop = (rl === 1'b1) || (r[m_idx] !== 1'b1);
            if (drop || m_held == int'(MAX_HOLD)) begin
                m_valid   = 0;
                m_ptr     = (int'(m_idx) + 1) % 8;
                m_timeout = !drop;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic tick();
        model_step(bus.req, bus.rel);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = 8'h00; bus.rel = 1'b0; rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = 8'h00; bus.rel = 1'b0; rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd0 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals got v/i/t=%b/%0d/%b want 0/0/0",
                     bus.grant_valid, bus.grant_idx, bus.timeout);
        end
        rst = 1'b0;
        bus.req = 8'h20;
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd5) begin
            failures++;
            $display("FAIL first_grant got v/i=%b/%0d want 1/5", bus.grant_valid, bus.grant_idx);
        end
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd0 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got v/i/t=%b/%0d/%b want 0/0/0",
                     bus.grant_valid, bus.grant_idx, bus.timeout);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd5) begin
            failures++;
            $display("FAIL regrant_after_reset got v/i=%b/%0d want 1/5",
                     bus.grant_valid, bus.grant_idx);
        end
    endtask

    task automatic test_rotation();
        int grants;
        int low;
        bit prev_valid;
        grants = 0; low = 0; prev_valid = 0;
        do_reset();
        bus.req = 8'hFF;
        for (int cyc = 0; cyc < 60 && grants < 9; cyc++) begin
            tick();
            checks++;
            if ({bus.grant_valid, bus.grant_idx, bus.timeout} !== {m_valid, m_idx, m_timeout}) begin
                failures++;
                $display("FAIL rotation cyc=%0d got v/i/t=%b/%0d/%b want %b/%0d/%b", cyc,
                         bus.grant_valid, bus.grant_idx, bus.timeout, m_valid, m_idx, m_timeout);
            end
            if (bus.grant_valid === 1'b1 && !prev_valid) begin
                checks++;
                if (bus.grant_idx !== 3'(grants % 8)) begin
                    failures++;
                    $display("FAIL rot_order n=%0d got %0d want %0d",
                             grants, bus.grant_idx, grants % 8);
                end
                if (grants > 0) begin
                    checks++;
                    if (low != 1) begin
                        failures++;
                        $display("FAIL rot_gap n=%0d got %0d low cycles want 1", grants, low);
                    end
                end
                grants++;
                low = 0;
            end
            if (bus.grant_valid !== 1'b1) low++;
            prev_valid = (bus.grant_valid === 1'b1);
            bus.rel = (m_valid && m_held == 3);
        end
        bus.rel = 1'b0;
        checks++;
        if (grants != 9) begin
            failures++;
            $display("FAIL rot_count got %0d grants want 9", grants);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req = 8'h20;
        tick();
        bus.rel = 1'b1;
        tick();
        bus.rel = 1'b0;
        bus.req = 8'h05;
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd0) begin
            failures++;
            $display("FAIL wrap_first got v/i=%b/%0d want 1/0", bus.grant_valid, bus.grant_idx);
        end
        bus.rel = 1'b1;
        tick();
        bus.rel = 1'b0;
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd2) begin
            failures++;
            $display("FAIL wrap_second got v/i=%b/%0d want 1/2", bus.grant_valid, bus.grant_idx);
        end
    endtask

    task automatic test_drop();
        do_reset();
        bus.req = 8'h08;
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd3) begin
            failures++;
            $display("FAIL drop_grant got v/i=%b/%0d want 1/3", bus.grant_valid, bus.grant_idx);
        end
        bus.req = 8'h8A;
        repeat (3) tick();
        bus.req = 8'h82;
        tick();
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL drop_end got v/t=%b/%b want 0/0", bus.grant_valid, bus.timeout);
        end
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd7) begin
            failures++;
            $display("FAIL drop_next got v/i=%b/%0d want 1/7", bus.grant_valid, bus.grant_idx);
        end
    endtask

    task automatic test_timeout();
        int high;
        high = 0;
        do_reset();
        bus.req = 8'h01;
        tick();
        for (int cyc = 0; cyc < 40 && bus.grant_valid === 1'b1; cyc++) begin
            high++;
            tick();
            checks++;
            if ({bus.grant_valid, bus.grant_idx, bus.timeout} !== {m_valid, m_idx, m_timeout}) begin
                failures++;
                $display("FAIL timeout_trace cyc=%0d got v/i/t=%b/%0d/%b want %b/%0d/%b", cyc,
                         bus.grant_valid, bus.grant_idx, bus.timeout, m_valid, m_idx, m_timeout);
            end
        end
        checks++;
        if (high != int'(MAX_HOLD)) begin
            failures++;
            $display("FAIL timeout_len got %0d cycles want %0d", high, MAX_HOLD);
        end
        checks++;
        if (bus.timeout !== 1'b1 || bus.grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse got v/t=%b/%b want 0/1", bus.grant_valid, bus.timeout);
        end
        tick();
        checks++;
        if (bus.timeout !== 1'b0 || bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd0) begin
            failures++;
            $display("FAIL timeout_regrant got v/i/t=%b/%0d/%b want 1/0/0",
                     bus.grant_valid, bus.grant_idx, bus.timeout);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.req = 8'h01;
        tick();
        repeat (MAX_HOLD - 1) tick();
        bus.rel = 1'b1;
        tick();
        bus.rel = 1'b0;
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL simul_no_timeout got v/t=%b/%b want 0/0", bus.grant_valid, bus.timeout);
        end
    endtask

    task automatic test_random();
        do_reset();
        bus.req = 8'hFF;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 7) == 0) bus.req = 8'($urandom | $urandom);
            if ($urandom_range(0, 9) == 0) bus.req = 8'($urandom & $urandom);
            bus.rel = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if ({bus.grant_valid, bus.grant_idx, bus.timeout} !== {m_valid, m_idx, m_timeout}) begin
                failures++;
                $display("FAIL random cyc=%0d got v/i/t=%b/%0d/%b want %b/%0d/%b", cyc,
                         bus.grant_valid, bus.grant_idx, bus.timeout, m_valid, m_idx, m_timeout);
            end
        end
        bus.rel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_drop();
        test_timeout();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb8_idx.md
Name: rr_arb8_idx

Overview:
- Round-robin arbiter for 8 requesters. Registers the index of the winning requester as a 3-bit binary code.
- Sits directly upstream of the 3-to-8 decoder: grant_idx drives the decoder input, and the decoder's one-hot output becomes the per-requester grant lines.
- Holds a grant until the owner releases it, drops its request, or exceeds a hold limit.

Parameters:
- N, 8, number of requesters; fixed at 8 for this block.
- IDX_W, 3, width of grant_idx; equals log2(N).
- MAX_HOLD, 16, maximum cycles a grant may be held before forced revocation; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  8  request vector; bit k = requester k wants the resource
- release  input  1  one-cycle pulse from the current owner ending its grant
- grant_valid  output  1  grant_idx is valid and the resource is owned
- grant_idx  output  3  binary index of the current owner; feeds the decoder
- timeout  output  1  one-cycle pulse: the grant was revoked by the MAX_HOLD limit

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values:
  - grant_valid=0, grant_idx=3'b000, timeout=0.
  - state=IDLE, priority pointer ptr=3'b000, hold counter=0.
  - Asserting rst mid-grant drops grant_valid immediately, with no timeout pulse.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first set bit scanning from ptr upward with wrap (ptr, ptr+1, ..., 7, 0, ..., ptr-1).
  - Register the pick into grant_idx, set grant_valid=1, clear the hold counter, go to GRANT.
  - If req==0, stay in IDLE; grant_idx keeps its last value.
  - Latency: a request sampled at edge t gives grant_valid=1 after edge t (visible in cycle t+1).
- GRANT:
  - The hold counter increments every cycle in GRANT (saturating width = clog2(MAX_HOLD+1)).
  - Exit conditions, all sampled at the same edge:
    - (a) release=1;
    - (b) req[grant_idx]=0;
    - (c) counter == MAX_HOLD-1, meaning the grant has been held MAX_HOLD cycles.
  - On any exit: grant_valid=0, ptr=grant_idx+1 (mod 8, wraps 7->0), go to IDLE.
  - timeout=1 for exactly one cycle, coincident with the grant_valid deassertion, only when (c) fires and neither (a) nor (b) fires.
  - Precedence: release/drop beat timeout.
  - grant_idx is stable for the whole GRANT period.
- Gap: at least one IDLE cycle between consecutive grants. Back-to-back owners see a minimum grant_valid low time of 1 cycle.
- Fairness: a continuously requesting agent waits at most 7 grants.
- release in IDLE is ignored. Requests arriving in GRANT do not affect the current grant.
- All outputs are registered; there is no combinational path from req or release to any output.

Decomposition:
- Shared package (arb_pkg) holds:
  - constants N=8 and IDX_W=3;
  - state enum {IDLE, GRANT};
  - default MAX_HOLD.
- One natural sub-module: rr_pick8. It is purely combinational: given req[7:0] and ptr[2:0], it returns any (1 bit) and idx[2:0], the first set bit at or after ptr with wrap. It is instantiated once.
- Counter, FSM and output registers live in the top.

Test Plan:
- Reset: rst=1 mid-grant with grant_idx=5 -> grant_valid=0 and grant_idx=0 immediately; after rst=0 with req=8'h20 -> grant_idx=5 one edge later.
- Rotation: req=8'hFF held, release pulsed on the 3rd GRANT cycle each time -> grant_idx sequence 0,1,2,...,7,0; one low cycle of grant_valid between each.
- Wrap scan: ptr=6 (after owner 5), req=8'b0000_0101 -> grant_idx=0, then after release grant_idx=2.
- Request drop: owner 3 granted, req[3] goes 0 at cycle 4 -> grant_valid=0 next edge, timeout=0, next owner searched from 4.
- Timeout: MAX_HOLD=16, req=8'h01 held, no release -> grant_valid high exactly 16 cycles, then timeout=1 for 1 cycle with grant_valid=0; re-grant of 0 two cycles later.
- Simultaneous: release=1 on the same edge the counter hits MAX_HOLD-1 -> grant ends and timeout stays 0.
